// File: rtl/speed_pkg.sv
// speed_pkg
//   Shared status encodings for the speed/pause interface between the button
//   control FSM (producer) and speed_stepper (consumer).
//   Codes: ST_LOW=0, ST_MID=1, ST_HIGH=2, ST_PAUSE=3.
package speed_pkg;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_MID   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_PAUSE = 2'd3
  } status_t;

  // Status value the stepper comes out of reset with.
  localparam status_t ST_RESET = ST_MID;

endpackage

// File: rtl/step_divider.sv
// step_divider
//   Step period divider. Holds the cycle counter, selects the step period
//   from the registered status and flags the terminal cycle of each step.
// Ports
//   clk     in  1      system clock, rising edge
//   rst     in  1      synchronous reset, active-high (cnt <= 0)
//   run     in  1      count enable; low freezes cnt (pause)
//   status  in  2      registered speed code selecting the period
//   term    out 1      high during the last cycle of a step (combinational)
module step_divider
  import speed_pkg::*;
#(
  parameter int DIV_LOW  = 50_000_000,
  parameter int DIV_MID  = 25_000_000,
  parameter int DIV_HIGH = 12_500_000,
  parameter int CNT_W    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  status_t          status,
  output logic             term
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;

  // Terminal count for the current speed. The pause code never reaches the
  // compare because run is low then; it simply shares the low-speed value.
  always_comb begin
    period_m1 = CNT_W'(DIV_LOW - 1);
    case (status)
      ST_LOW:  period_m1 = CNT_W'(DIV_LOW - 1);
      ST_MID:  period_m1 = CNT_W'(DIV_MID - 1);
      ST_HIGH: period_m1 = CNT_W'(DIV_HIGH - 1);
      default: period_m1 = CNT_W'(DIV_LOW - 1);
    endcase
  end

  // ">=" rather than "==": after a speed-up leaves cnt beyond the new
  // terminal count, the step fires immediately instead of waiting for wrap.
  assign term = run && (cnt >= period_m1);

  // Counter is never cleared by a speed change, only by a step or reset,
  // so slow-downs stretch the current step and pauses keep partial progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      if (term) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/speed_stepper.sv
// speed_stepper
//   Turns the 2-bit speed/pause status into a timed step stream. Each step
//   pulses step_tick for one cycle, rotates a one-hot LED pattern and
//   advances a 16-bit step counter.
// Ports
//   clk         in  1      system clock, rising edge
//   rst         in  1      synchronous reset, active-high
//   status      in  2      0 low, 1 mid, 2 high, 3 pause
//   dir         in  1      0 rotate toward MSB, 1 rotate toward LSB
//   step_tick   out 1      one-cycle pulse per step
//   led         out LED_N  one-hot position
//   step_count  out 16     steps taken, wraps modulo 2**16
//   paused      out 1      high while registered status is pause
module speed_stepper
  import speed_pkg::*;
#(
  parameter int DIV_LOW  = 50_000_000,
  parameter int DIV_MID  = 25_000_000,
  parameter int DIV_HIGH = 12_500_000,
  parameter int CNT_W    = 27,
  parameter int LED_N    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       status,
  input  logic             dir,
  output logic             step_tick,
  output logic [LED_N-1:0] led,
  output logic [15:0]      step_count,
  output logic             paused
);

  status_t status_q;
  logic    run;
  logic    term;

  assign run = (status_q != ST_PAUSE);

  // One register stage on the incoming status; paused follows it by one
  // more edge since it is derived from the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= ST_RESET;
      paused   <= 1'b0;
    end else begin
      status_q <= status_t'(status);
      paused   <= (status_q == ST_PAUSE);
    end
  end

  step_divider #(
    .DIV_LOW  (DIV_LOW),
    .DIV_MID  (DIV_MID),
    .DIV_HIGH (DIV_HIGH),
    .CNT_W    (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .status (status_q),
    .term   (term)
  );

  // Step outputs all update on the edge that ends the terminal cycle, so
  // step_tick is high exactly while led/step_count show the new step.
  // dir is only looked at here, which makes a change take effect at the
  // next step. Rotation of a one-hot value keeps it one-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_tick  <= 1'b0;
      led        <= LED_N'(1);
      step_count <= '0;
    end else begin
      step_tick <= term;
      if (term) begin
        if (dir) led <= {led[0], led[LED_N-1:1]};
        else     led <= {led[LED_N-2:0], led[LED_N-1]};
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_speed_stepper.sv
// tb_speed_stepper
//   Directed bench for speed_stepper with small dividers (8/4/2) so steps
//   come every few cycles. Each task drives one scenario and checks the
//   outputs against hand-computed values one cycle at a time.
module tb_speed_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] status;
  logic       dir;
  logic       step_tick;
  logic [7:0] led;
  logic [15:0] step_count;
  logic       paused;

  int tests_run = 0;
  int failures  = 0;

  speed_stepper #(
    .DIV_LOW  (8),
    .DIV_MID  (4),
    .DIV_HIGH (2),
    .CNT_W    (27),
    .LED_N    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .status     (status),
    .dir        (dir),
    .step_tick  (step_tick),
    .led        (led),
    .step_count (step_count),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; status = 2'd1; dir = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if (step_tick !== 1'b0 || led !== 8'h01 || step_count !== 16'd0 || paused !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset: got tick=%b led=%h cnt=%0d paused=%b want tick=0 led=01 cnt=0 paused=0",
               step_tick, led, step_count, paused);
    end
    rst = 1'b0;
  endtask

  // Mid speed: three quiet edges then a tick, led walking toward the MSB.
  task automatic test_mid_run();
    logic [7:0] exp_led;
    for (int k = 1; k <= 12; k++) begin
      for (int c = 0; c < 3; c++) begin
        cycle();
        tests_run++;
        if (step_tick !== 1'b0) begin
          failures++;
          $display("[TB] FAIL mid_gap step %0d: got tick=%b want 0", k, step_tick);
        end
      end
      cycle();
      exp_led = 8'h01 << (k % 8);
      tests_run++;
      if (step_tick !== 1'b1 || led !== exp_led || step_count !== 16'(k)) begin
        failures++;
        $display("[TB] FAIL mid_tick step %0d: got tick=%b led=%h cnt=%0d want tick=1 led=%h cnt=%0d",
                 k, step_tick, led, step_count, exp_led, k);
      end
    end
  endtask

  // Pause with cnt frozen at 2, then resume: tick after the remaining counts.
  task automatic test_pause();
    cycle();
    status = 2'd3;
    cycle();
    tests_run++;
    if (paused !== 1'b0 || step_tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pause_edge1: got paused=%b tick=%b want paused=0 tick=0", paused, step_tick);
    end
    for (int c = 0; c < 19; c++) begin
      cycle();
      tests_run++;
      if (paused !== 1'b1 || step_tick !== 1'b0 || led !== 8'h10 || step_count !== 16'd12) begin
        failures++;
        $display("[TB] FAIL pause_hold %0d: got paused=%b tick=%b led=%h cnt=%0d want 1 0 10 12",
                 c, paused, step_tick, led, step_count);
      end
    end
    status = 2'd1;
    cycle();
    tests_run++;
    if (paused !== 1'b1 || step_tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL resume_edge1: got paused=%b tick=%b want paused=1 tick=0", paused, step_tick);
    end
    cycle();
    tests_run++;
    if (paused !== 1'b0 || step_tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL resume_edge2: got paused=%b tick=%b want paused=0 tick=0", paused, step_tick);
    end
    cycle();
    tests_run++;
    if (step_tick !== 1'b1 || led !== 8'h20 || step_count !== 16'd13) begin
      failures++;
      $display("[TB] FAIL resume_tick: got tick=%b led=%h cnt=%0d want tick=1 led=20 cnt=13",
               step_tick, led, step_count);
    end
  endtask

  // Low speed up to cnt=5, then high speed: immediate tick, then every 2.
  task automatic test_speedup();
    logic [7:0] exp_led [3] = '{8'h40, 8'h80, 8'h01};
    status = 2'd0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests_run++;
      if (step_tick !== 1'b0) begin
        failures++;
        $display("[TB] FAIL low_gap %0d: got tick=%b want 0", c, step_tick);
      end
    end
    status = 2'd2;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++;
      if (step_tick !== 1'b0) begin
        failures++;
        $display("[TB] FAIL fast_gap %0d: got tick=%b want 0", k, step_tick);
      end
      cycle();
      tests_run++;
      if (step_tick !== 1'b1 || led !== exp_led[k] || step_count !== 16'(14 + k)) begin
        failures++;
        $display("[TB] FAIL fast_tick %0d: got tick=%b led=%h cnt=%0d want tick=1 led=%h cnt=%0d",
                 k, step_tick, led, step_count, exp_led[k], 14 + k);
      end
    end
  endtask

  // Direction changes only apply at a terminal cycle.
  task automatic test_dir();
    logic [7:0] exp_led [4] = '{8'h80, 8'h40, 8'h20, 8'h40};
    dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if (step_tick !== 1'b0) begin
        failures++;
        $display("[TB] FAIL dir_gap %0d: got tick=%b want 0", k, step_tick);
      end
      if (k == 2) dir = 1'b1;
      cycle();
      tests_run++;
      if (step_tick !== 1'b1 || led !== exp_led[k] || step_count !== 16'(17 + k)) begin
        failures++;
        $display("[TB] FAIL dir_tick %0d: got tick=%b led=%h cnt=%0d want tick=1 led=%h cnt=%0d",
                 k, step_tick, led, step_count, exp_led[k], 17 + k);
      end
      // A short dir=0 pulse in a non-terminal cycle before step 2 is ignored.
      if (k == 1) dir = 1'b0;
      if (k == 2) dir = 1'b0;
    end
  endtask

  // Run the step counter through its wrap at high speed.
  task automatic test_wrap();
    int total_cycles = 0;
    int waited;
    for (int n = 1; n <= 65520; n++) begin
      waited = 0;
      do begin
        cycle();
        waited++;
      end while (step_tick !== 1'b1 && waited < 4);
      total_cycles += waited;
      if (step_tick !== 1'b1) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL wrap_timeout: step %0d got no tick in %0d cycles", n, waited);
        return;
      end
      if (n == 65515) begin
        tests_run++;
        if (step_count !== 16'hFFFF) begin
          failures++;
          $display("[TB] FAIL wrap_ffff: got cnt=%h want ffff", step_count);
        end
      end
      if (n == 65516) begin
        tests_run++;
        if (step_count !== 16'h0000 || led !== 8'h04) begin
          failures++;
          $display("[TB] FAIL wrap_zero: got cnt=%h led=%h want cnt=0000 led=04", step_count, led);
        end
      end
    end
    tests_run++;
    if (step_count !== 16'd4 || led !== 8'h40 || total_cycles != 131040) begin
      failures++;
      $display("[TB] FAIL wrap_end: got cnt=%0d led=%h cycles=%0d want cnt=4 led=40 cycles=131040",
               step_count, led, total_cycles);
    end
  endtask

  // Reset pulses mid-count, on a terminal cycle and during pause.
  task automatic test_reset_mid();
    status = 2'd1;
    cycle();
    cycle();
    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        status = 2'd3;
        cycle();
        cycle();
        tests_run++;
        if (paused !== 1'b1) begin
          failures++;
          $display("[TB] FAIL pre_reset_pause: got paused=%b want 1", paused);
        end
        status = 2'd1;
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      tests_run++;
      if (step_tick !== 1'b0 || led !== 8'h01 || step_count !== 16'd0 || paused !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_mid %0d: got tick=%b led=%h cnt=%0d paused=%b want 0 01 0 0",
                 r, step_tick, led, step_count, paused);
      end
      for (int c = 0; c < 3; c++) begin
        cycle();
        tests_run++;
        if (step_tick !== 1'b0) begin
          failures++;
          $display("[TB] FAIL post_reset_gap %0d/%0d: got tick=%b want 0", r, c, step_tick);
        end
      end
      // r==0: leave the terminal cycle to the next iteration's reset pulse.
      if (r != 0) begin
        cycle();
        tests_run++;
        if (step_tick !== 1'b1 || led !== 8'h02 || step_count !== 16'd1) begin
          failures++;
          $display("[TB] FAIL post_reset_tick %0d: got tick=%b led=%h cnt=%0d want 1 02 1",
                   r, step_tick, led, step_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mid_run();
    test_pause();
    test_speedup();
    test_dir();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
